inst_memory_loadable: RTL and testbench

INST_MEMORY_LOADABLE -- requirements
Module: inst_memory_loadable

---
 rtl/inst_memory_loadable.sv | 195 +++++++++++++++++++
 tb/tb_inst_memory_loadable.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_memory_loadable.sv
// Instruction memory that fills itself with a NOP word after reset, serves
// single-cycle-latency fetches, and accepts a byte-serial program load.
module inst_memory_loadable #(
    parameter int                DATA_W = 32,
    parameter int                ADDR_W = 8,
    parameter int                DEPTH  = 256,
    parameter logic [DATA_W-1:0] FILL   = DATA_W'(32'h00000013)
) (
    input  logic              clk,
    input  logic              reset,
    // Handshakes: fetch_req/fetch_ready and load_valid/load_ready each
    // transfer on a rising edge where both are high; the ready side never
    // waits on the valid side, and fetch_valid is a single-cycle
    // response qualifier with no back-pressure.
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_fault,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_words,
    output logic              load_overflow,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     ptr_q, ptr_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic                fvalid_q, fvalid_d;
    logic [DATA_W-1:0]   fdata_q, fdata_d;
    logic                ffault_q, ffault_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                fetch_accept;
    logic                addr_ok;
    logic                load_accept;
    logic                word_full;
    logic                room;
    logic [DATA_W-1:0]   lane_word;

    assign fetch_accept = fetch_req && (state_q == ST_IDLE);
    assign addr_ok      = ({1'b0, fetch_addr} < DEPTH_C);
    assign load_accept  = load_valid && (state_q == ST_LOAD);
    // Lanes above the current one are already zero because the assembly
    // register is cleared on every word write, so a short final word is
    // zero-padded for free.
    assign lane_word    = asm_q | (DATA_W'(load_byte) << {lane_q, 3'b000});
    assign word_full    = (lane_q == LAST_LANE) || load_last;
    assign room         = (ptr_q < DEPTH_C);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lane_d    = lane_q;
        asm_d     = asm_q;
        words_d   = words_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        fvalid_d  = fetch_accept;
        fdata_d   = fdata_q;
        ffault_d  = ffault_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q[IDX_W-1:0];
        mem_wdata = FILL;

        if (fetch_accept) begin
            fdata_d  = addr_ok ? mem_q[fetch_addr[IDX_W-1:0]] : '0;
            ffault_d = !addr_ok;
        end

        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    lane_d  = '0;
                    asm_d   = '0;
                    words_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (load_accept) begin
                    // Any byte arriving once the memory is full is dropped.
                    if (!room) begin
                        ovf_d = 1'b1;
                    end
                    if (word_full) begin
                        asm_d  = '0;
                        lane_d = '0;
                        if (room) begin
                            mem_we    = 1'b1;
                            mem_wdata = lane_word;
                            ptr_d     = ptr_q + 1'b1;
                            words_d   = words_q + 1'b1;
                        end
                    end else begin
                        asm_d  = lane_word;
                        lane_d = lane_q + 1'b1;
                    end
                    if (load_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_CLEAR;
            ptr_q    <= '0;
            lane_q   <= '0;
            asm_q    <= '0;
            words_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            fvalid_q <= 1'b0;
            fdata_q  <= '0;
            ffault_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            lane_q   <= lane_d;
            asm_q    <= asm_d;
            words_q  <= words_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            fvalid_q <= fvalid_d;
            fdata_q  <= fdata_d;
            ffault_q <= ffault_d;
        end
    end

    // Storage has no reset; CLEAR rewrites every word after reset release.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign fetch_ready   = (state_q == ST_IDLE);
    assign load_ready    = (state_q == ST_LOAD);
    assign busy          = (state_q != ST_IDLE);
    assign fetch_valid   = fvalid_q;
    assign fetch_data    = fdata_q;
    assign fetch_fault   = ffault_q;
    assign load_done     = done_q;
    assign load_words    = words_q;
    assign load_overflow = ovf_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_inst_memory_loadable.sv
// Directed bench for inst_memory_loadable: a default-size instance plus a
// DEPTH=4 instance used for the overflow and fault cases.
`timescale 1ns/1ps
module tb_inst_memory_loadable;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        f_req = 1'b0;
  logic [7:0]  f_addr = '0;
  logic        f_ready, f_valid, f_fault;
  logic [31:0] f_data;
  logic        l_start = 1'b0, l_valid = 1'b0, l_last = 1'b0;
  logic [7:0]  l_byte = '0;
  logic        l_ready, l_done, l_ovf, busy;
  logic [8:0]  l_words;
  logic [1:0]  dbg;

  logic        s_req = 1'b0;
  logic [2:0]  s_addr = '0;
  logic        s_ready, s_valid, s_fault;
  logic [31:0] s_data;
  logic        s_start = 1'b0, s_lvalid = 1'b0, s_last = 1'b0;
  logic [7:0]  s_byte = '0;
  logic        s_lready, s_done, s_ovf, s_busy;
  logic [3:0]  s_words;
  logic [1:0]  s_dbg;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt;
  logic [7:0] byte_q[$];

  always #5 clk = ~clk;

  inst_memory_loadable dut (
    .clk(clk), .reset(reset),
    .fetch_req(f_req), .fetch_addr(f_addr), .fetch_ready(f_ready),
    .fetch_valid(f_valid), .fetch_data(f_data), .fetch_fault(f_fault),
    .load_start(l_start), .load_valid(l_valid), .load_byte(l_byte),
    .load_last(l_last), .load_ready(l_ready), .load_done(l_done),
    .load_words(l_words), .load_overflow(l_ovf), .busy(busy),
    .dbg_state(dbg)
  );

  inst_memory_loadable #(.DATA_W(32), .ADDR_W(3), .DEPTH(4)) dut_small (
    .clk(clk), .reset(reset),
    .fetch_req(s_req), .fetch_addr(s_addr), .fetch_ready(s_ready),
    .fetch_valid(s_valid), .fetch_data(s_data), .fetch_fault(s_fault),
    .load_start(s_start), .load_valid(s_lvalid), .load_byte(s_byte),
    .load_last(s_last), .load_ready(s_lready), .load_done(s_done),
    .load_words(s_words), .load_overflow(s_ovf), .busy(s_busy),
    .dbg_state(s_dbg)
  );

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for fetch_ready on the main instance, returns cycles seen low.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!f_ready && cycles < 400) begin
      cycles++;
      if (f_valid) begin
        n_fail++;
        $display("FAIL valid_during_clear: got fetch_valid=1 expected 0");
      end
      step();
    end
  endtask

  task automatic fetch_main(input logic [7:0] a);
    f_req = 1'b1;
    f_addr = a;
    step();
    f_req = 1'b0;
  endtask

  task automatic fetch_small(input logic [2:0] a);
    s_req = 1'b1;
    s_addr = a;
    step();
    s_req = 1'b0;
  endtask

  // Streams byte_q[0..n-1] into the main instance, load_last on the final byte.
  task automatic load_main(input int n, input bit do_start);
    done_cnt = 0;
    if (do_start) begin
      l_start = 1'b1;
      step();
      l_start = 1'b0;
    end
    n_checks++;
    if (l_ready !== 1'b1 || f_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_entry: got load_ready=%b fetch_ready=%b expected 1 0", l_ready, f_ready);
    end
    for (int i = 0; i < n; i++) begin
      l_valid = 1'b1;
      l_byte = byte_q[i];
      l_last = (i == n - 1);
      step();
      if (l_done) done_cnt++;
    end
    l_valid = 1'b0;
    l_last = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_checks++;
    if (busy !== 1'b1 || f_ready !== 1'b0 || l_ready !== 1'b0 || dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy=%b fready=%b lready=%b state=%0d expected 1 0 0 0",
               busy, f_ready, l_ready, dbg);
    end
    n_checks++;
    if (f_valid !== 1'b0 || f_data !== 32'h0 || f_fault !== 1'b0 ||
        l_done !== 1'b0 || l_words !== 9'd0 || l_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b data=%h fault=%b done=%b words=%0d ovf=%b expected all zero",
               f_valid, f_data, f_fault, l_done, l_words, l_ovf);
    end
  endtask

  task automatic test_clear();
    int cyc;
    reset = 1'b0;
    f_req = 1'b1;
    f_addr = 8'd5;
    wait_ready(cyc);
    n_checks++;
    if (cyc !== 256) begin
      n_fail++;
      $display("FAIL clear_length: got %0d cycles expected 256", cyc);
    end
    step();
    f_req = 1'b0;
    n_checks++;
    if (f_valid !== 1'b1 || f_data !== 32'h00000013 || f_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_fill_fetch: got valid=%b data=%h fault=%b expected 1 00000013 0",
               f_valid, f_data, f_fault);
    end
    step();
    n_checks++;
    if (f_valid !== 1'b0 || f_data !== 32'h00000013) begin
      n_fail++;
      $display("FAIL fetch_hold: got valid=%b data=%h expected 0 00000013", f_valid, f_data);
    end
  endtask

  task automatic test_load_two_words();
    byte_q = '{8'h03, 8'h30, 8'h00, 8'h00, 8'h83, 8'h30, 8'h10, 8'h00};
    load_main(8, 1'b1);
    n_checks++;
    if (l_done !== 1'b1 || done_cnt !== 1 || l_words !== 9'd2 || f_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load2_end: got done=%b pulses=%0d words=%0d fready=%b expected 1 1 2 1",
               l_done, done_cnt, l_words, f_ready);
    end
    fetch_main(8'd0);
    n_checks++;
    if (f_valid !== 1'b1 || f_data !== 32'h00003003 || l_done !== 1'b0) begin
      n_fail++;
      $display("FAIL load2_word0: got valid=%b data=%h done=%b expected 1 00003003 0",
               f_valid, f_data, l_done);
    end
    fetch_main(8'd1);
    n_checks++;
    if (f_valid !== 1'b1 || f_data !== 32'h00103083) begin
      n_fail++;
      $display("FAIL load2_word1: got valid=%b data=%h expected 1 00103083", f_valid, f_data);
    end
    fetch_main(8'd2);
    n_checks++;
    if (f_data !== 32'h00000013 || l_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL load2_untouched: got data=%h ovf=%b expected 00000013 0", f_data, l_ovf);
    end
  endtask

  task automatic test_partial_word();
    byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    load_main(5, 1'b1);
    n_checks++;
    if (l_words !== 9'd2 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL partial_count: got words=%0d pulses=%0d expected 2 1", l_words, done_cnt);
    end
    fetch_main(8'd1);
    n_checks++;
    if (f_data !== 32'h000000EE) begin
      n_fail++;
      $display("FAIL partial_pad: got %h expected 000000ee", f_data);
    end
    fetch_main(8'd0);
    n_checks++;
    if (f_data !== 32'hDDCCBBAA) begin
      n_fail++;
      $display("FAIL partial_word0: got %h expected ddccbbaa", f_data);
    end
  endtask

  task automatic test_fetch_and_load_same_cycle();
    f_req = 1'b1;
    f_addr = 8'd1;
    l_start = 1'b1;
    step();
    l_start = 1'b0;
    n_checks++;
    if (f_valid !== 1'b1 || f_data !== 32'h000000EE || busy !== 1'b1 || f_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle: got valid=%b data=%h busy=%b fready=%b expected 1 000000ee 1 0",
               f_valid, f_data, busy, f_ready);
    end
    step();
    f_req = 1'b0;
    n_checks++;
    if (f_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_ignored_in_load: got valid=%b expected 0", f_valid);
    end
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_main(4, 1'b0);
    n_checks++;
    if (l_words !== 9'd1 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL boundary_last: got words=%0d pulses=%0d expected 1 1", l_words, done_cnt);
    end
    fetch_main(8'd0);
    n_checks++;
    if (f_data !== 32'h44332211) begin
      n_fail++;
      $display("FAIL boundary_word0: got %h expected 44332211", f_data);
    end
    fetch_main(8'd1);
    n_checks++;
    if (f_data !== 32'h000000EE) begin
      n_fail++;
      $display("FAIL boundary_no_empty_word: got %h expected 000000ee", f_data);
    end
    fetch_main(8'd0);
  endtask

  task automatic test_overflow();
    int pulses;
    pulses = 0;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_lvalid = 1'b1;
      s_byte = 8'(i + 1);
      s_last = (i == 19);
      step();
      if (s_done) pulses++;
    end
    s_lvalid = 1'b0;
    s_last = 1'b0;
    n_checks++;
    if (s_words !== 4'd4 || s_ovf !== 1'b1 || pulses !== 1) begin
      n_fail++;
      $display("FAIL overflow_flags: got words=%0d ovf=%b pulses=%0d expected 4 1 1",
               s_words, s_ovf, pulses);
    end
    fetch_small(3'd3);
    n_checks++;
    if (s_data !== 32'h100F0E0D || s_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_last_word: got data=%h fault=%b expected 100f0e0d 0", s_data, s_fault);
    end
    fetch_small(3'd6);
    n_checks++;
    if (s_valid !== 1'b1 || s_data !== 32'h0 || s_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_addr6: got valid=%b data=%h fault=%b expected 1 00000000 1",
               s_valid, s_data, s_fault);
    end
    fetch_small(3'd0);
    n_checks++;
    if (s_data !== 32'h04030201 || s_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_word0: got data=%h fault=%b expected 04030201 0", s_data, s_fault);
    end
    fetch_small(3'd4);
    n_checks++;
    if (s_data !== 32'h0 || s_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_addr4: got data=%h fault=%b expected 00000000 1", s_data, s_fault);
    end
  endtask

  task automatic test_reset_mid_load();
    int cyc;
    l_start = 1'b1;
    step();
    l_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      l_valid = 1'b1;
      l_byte = 8'hA0 + 8'(i);
      step();
    end
    l_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b1 || dbg !== 2'd0 || l_ready !== 1'b0 || f_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_reset_ctrl: got busy=%b state=%0d lready=%b fready=%b expected 1 0 0 0",
               busy, dbg, l_ready, f_ready);
    end
    n_checks++;
    if (f_valid !== 1'b0 || f_data !== 32'h0 || f_fault !== 1'b0 ||
        l_done !== 1'b0 || l_words !== 9'd0 || l_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_reset_outputs: got valid=%b data=%h fault=%b done=%b words=%0d ovf=%b expected all zero",
               f_valid, f_data, f_fault, l_done, l_words, l_ovf);
    end
    step();
    step();
    reset = 1'b0;
    wait_ready(cyc);
    n_checks++;
    if (cyc !== 256) begin
      n_fail++;
      $display("FAIL reclear_length: got %0d cycles expected 256", cyc);
    end
    fetch_main(8'd0);
    n_checks++;
    if (f_data !== 32'h00000013) begin
      n_fail++;
      $display("FAIL reclear_word0: got %h expected 00000013", f_data);
    end
    fetch_main(8'd1);
    n_checks++;
    if (f_data !== 32'h00000013) begin
      n_fail++;
      $display("FAIL reclear_word1: got %h expected 00000013", f_data);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_load_two_words();
    test_partial_word();
    test_fetch_and_load_same_cycle();
    test_overflow();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
